// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller: state
// enumeration, opcode/funct values and datapath select encodings.
package cpu_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH      = 5'd1,
        S_DECODE     = 5'd2,
        S_EXEC_R     = 5'd3,
        S_R_WB       = 5'd4,
        S_SHIFT_LOAD = 5'd5,
        S_SHIFT_OP   = 5'd6,
        S_SHIFT_WB   = 5'd7,
        S_JUMP_REG   = 5'd8,
        S_EXEC_I     = 5'd9,
        S_I_WB       = 5'd10,
        S_MEM_ADDR   = 5'd11,
        S_MEM_READ   = 5'd12,
        S_MEM_WB     = 5'd13,
        S_MEM_WRITE  = 5'd14,
        S_BRANCH     = 5'd15,
        S_JUMP       = 5'd16,
        S_EXC        = 5'd17
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;

    localparam logic [2:0] SH_NOP  = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_SHL  = 3'b010;
    localparam logic [2:0] SH_SHR  = 3'b011;
    localparam logic [2:0] SH_SRA  = 3'b100;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_AREG   = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    typedef struct packed {
        logic       pc_write;
        logic [1:0] pc_source;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dest;
        logic       mem_to_reg;
        logic       write_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic       alu_out_write;
        logic [2:0] shift_control;
        logic       exception;
    } ctrl_t;

    function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic logic [2:0] shift_for_funct(input logic [5:0] fn);
        case (fn)
            FN_SLL:  return SH_SHL;
            FN_SRL:  return SH_SHR;
            FN_SRA:  return SH_SRA;
            default: return SH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Controller <-> datapath signal bundle. master = control unit, slave = datapath.
interface control_unit_if;

    logic [5:0] OPCODE;
    logic [5:0] Funct;
    logic       Zero;
    logic       Overflow;

    logic       PCwrite;
    logic [1:0] PCSource;
    logic       MemWrite;
    logic       IorD;
    logic       IRWrite;
    logic       RegWrite;
    logic       RegDest;
    logic       MemToReg;
    logic       WriteSrc;
    logic       AluSrcA;
    logic [1:0] AluSrcB;
    logic [2:0] ALUControl;
    logic       ALUOutWrite;
    logic [2:0] ShiftControl;
    logic       Exception;
    logic [4:0] State;

    modport master (
        input  OPCODE, Funct, Zero, Overflow,
        output PCwrite, PCSource, MemWrite, IorD, IRWrite, RegWrite, RegDest,
               MemToReg, WriteSrc, AluSrcA, AluSrcB, ALUControl, ALUOutWrite,
               ShiftControl, Exception, State
    );

    modport slave (
        output OPCODE, Funct, Zero, Overflow,
        input  PCwrite, PCSource, MemWrite, IorD, IRWrite, RegWrite, RegDest,
               MemToReg, WriteSrc, AluSrcA, AluSrcB, ALUControl, ALUOutWrite,
               ShiftControl, Exception, State
    );

endinterface

// File: rtl/mem_wait_counter.sv
// Saturating dwell counter: cleared synchronously, counts up to MEM_WAIT-1
// and holds there; done_o flags the final cycle of a MEM_WAIT-cycle dwell.
module mem_wait_counter #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic clk_i,
    input  logic clear_i,
    output logic done_o
);

    localparam int unsigned W = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [W-1:0] LAST = W'(MEM_WAIT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: clear has priority, otherwise step until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == LAST);

endmodule

// File: rtl/control_unit.sv
// Multicycle Moore controller for the MIPS-subset CPU.
// Optional feature macro: OVERFLOW_TRAP_EN (add/sub/addi overflow suppresses
// the register write and diverts through the EXC state).
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT           = 1,
    parameter int unsigned RESET_STATE_CYCLES = 1
) (
    input  logic            clk,
    input  logic            reset,
    control_unit_if.master  bus
);

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] funct_q, funct_d;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic       mem_done;
    logic       rst_done;
    logic       cnt_clear;

    // Both dwell counters restart on every state change and while in reset.
    assign cnt_clear = reset || (state_d != state_q);

    mem_wait_counter #(.MEM_WAIT(MEM_WAIT)) u_mem_wait (
        .clk_i   (clk),
        .clear_i (cnt_clear),
        .done_o  (mem_done)
    );

    mem_wait_counter #(.MEM_WAIT(RESET_STATE_CYCLES)) u_reset_wait (
        .clk_i   (clk),
        .clear_i (cnt_clear),
        .done_o  (rst_done)
    );

    // State register plus opcode/funct captured in DECODE so later states
    // decode from registered values only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RESET;
            op_q    <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            funct_q <= funct_d;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        funct_d = funct_q;
        ctrl    = '0;
        case (state_q)
            S_RESET: begin
                if (rst_done) state_d = S_FETCH;
            end
            S_FETCH: begin
                ctrl.iord = 1'b0;
                if (mem_done) begin
                    ctrl.ir_write    = 1'b1;
                    ctrl.alu_src_a   = 1'b0;
                    ctrl.alu_src_b   = SRCB_FOUR;
                    ctrl.alu_control = ALU_ADD;
                    ctrl.pc_source   = PCS_ALU;
                    ctrl.pc_write    = 1'b1;
                    state_d          = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl.alu_src_a     = 1'b0;
                ctrl.alu_src_b     = SRCB_SEXT_SH;
                ctrl.alu_control   = ALU_ADD;
                ctrl.alu_out_write = 1'b1;
                op_d               = bus.OPCODE;
                funct_d            = bus.Funct;
                case (bus.OPCODE)
                    OP_RTYPE: begin
                        case (bus.Funct)
                            FN_ADD, FN_SUB, FN_AND: state_d = S_EXEC_R;
                            FN_SLL, FN_SRL, FN_SRA: state_d = S_SHIFT_LOAD;
                            FN_JR:                  state_d = S_JUMP_REG;
                            default:                state_d = S_FETCH;
                        endcase
                    end
                    OP_ADDI:       state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_control   = alu_for_funct(funct_q);
                ctrl.alu_out_write = 1'b1;
                state_d            = S_R_WB;
            end
            S_R_WB: begin
                ctrl.reg_dest   = 1'b1;
                ctrl.write_src  = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
                state_d         = S_FETCH;
`ifdef OVERFLOW_TRAP_EN
                if (funct_q != FN_AND && bus.Overflow) begin
                    ctrl.reg_write = 1'b0;
                    state_d        = S_EXC;
                end
`endif
            end
            S_SHIFT_LOAD: begin
                ctrl.shift_control = SH_LOAD;
                state_d            = S_SHIFT_OP;
            end
            S_SHIFT_OP: begin
                ctrl.shift_control = shift_for_funct(funct_q);
                state_d            = S_SHIFT_WB;
            end
            S_SHIFT_WB: begin
                ctrl.reg_dest  = 1'b1;
                ctrl.write_src = 1'b1;
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_JUMP_REG: begin
                ctrl.pc_source = PCS_AREG;
                ctrl.pc_write  = 1'b1;
                state_d        = S_FETCH;
            end
            S_EXEC_I, S_MEM_ADDR: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_SEXT;
                ctrl.alu_control   = ALU_ADD;
                ctrl.alu_out_write = 1'b1;
                if (state_q == S_EXEC_I) state_d = S_I_WB;
                else if (op_q == OP_LW)  state_d = S_MEM_READ;
                else                     state_d = S_MEM_WRITE;
            end
            S_I_WB: begin
                ctrl.reg_dest  = 1'b0;
                ctrl.reg_write = 1'b1;
                state_d        = S_FETCH;
`ifdef OVERFLOW_TRAP_EN
                if (bus.Overflow) begin
                    ctrl.reg_write = 1'b0;
                    state_d        = S_EXC;
                end
`endif
            end
            S_MEM_READ: begin
                ctrl.iord = 1'b1;
                if (mem_done) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_dest   = 1'b0;
                ctrl.reg_write  = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a   = 1'b1;
                ctrl.alu_src_b   = SRCB_B;
                ctrl.alu_control = ALU_SUB;
                ctrl.pc_source   = PCS_ALUOUT;
                ctrl.pc_write    = (op_q == OP_BNE) ? ~bus.Zero : bus.Zero;
                state_d          = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_source = PCS_JUMP;
                ctrl.pc_write  = 1'b1;
                state_d        = S_FETCH;
            end
`ifdef OVERFLOW_TRAP_EN
            S_EXC: begin
                ctrl.exception = 1'b1;
                ctrl.pc_source = PCS_JUMP;
                ctrl.pc_write  = 1'b1;
                state_d        = S_FETCH;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every output immediately so an aborted instruction
    // cannot write anything in the reset cycle itself.
    assign ctrl_out = reset ? '0 : ctrl;

    assign bus.PCwrite      = ctrl_out.pc_write;
    assign bus.PCSource     = ctrl_out.pc_source;
    assign bus.MemWrite     = ctrl_out.mem_write;
    assign bus.IorD         = ctrl_out.iord;
    assign bus.IRWrite      = ctrl_out.ir_write;
    assign bus.RegWrite     = ctrl_out.reg_write;
    assign bus.RegDest      = ctrl_out.reg_dest;
    assign bus.MemToReg     = ctrl_out.mem_to_reg;
    assign bus.WriteSrc     = ctrl_out.write_src;
    assign bus.AluSrcA      = ctrl_out.alu_src_a;
    assign bus.AluSrcB      = ctrl_out.alu_src_b;
    assign bus.ALUControl   = ctrl_out.alu_control;
    assign bus.ALUOutWrite  = ctrl_out.alu_out_write;
    assign bus.ShiftControl = ctrl_out.shift_control;
    assign bus.State        = reset ? S_RESET : state_q;

`ifdef OVERFLOW_TRAP_EN
    assign bus.Exception    = ctrl_out.exception;
`else
    logic unused_overflow;
    assign unused_overflow  = bus.Overflow;
    assign bus.Exception    = 1'b0;
`endif

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  import cpu_ctrl_pkg::*;

  localparam int MEM_WAIT = 2;
  localparam int RSC      = 1;
`ifdef OVERFLOW_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic       pcw;
    logic [1:0] pcs;
    logic       memw;
    logic       iord;
    logic       irw;
    logic       regw;
    logic       regd;
    logic       m2r;
    logic       wsrc;
    logic       srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic       aluow;
    logic [2:0] sh;
    logic       exc;
  } ctl_t;

  typedef struct packed {
    ctl_t       c;
    logic       cs;
    logic [4:0] st;
  } exp_t;

  exp_t exp_q[$];
  exp_t seq_q[$];

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [5:0] cur_op, cur_fn;

  control_unit_if bus();

  control_unit #(.MEM_WAIT(MEM_WAIT), .RESET_STATE_CYCLES(RSC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t e;
    ctl_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{bus.PCwrite, bus.PCSource, bus.MemWrite, bus.IorD, bus.IRWrite,
            bus.RegWrite, bus.RegDest, bus.MemToReg, bus.WriteSrc, bus.AluSrcA,
            bus.AluSrcB, bus.ALUControl, bus.ALUOutWrite, bus.ShiftControl,
            bus.Exception};
      tests++;
      if (a !== e.c || (e.cs && bus.State !== e.st)) begin
        fails++;
        $display("FAIL ctl op=%h fn=%h t=%0t: got ctl=%h state=%0d, want ctl=%h state=%0d(chk=%0d)",
                 cur_op, cur_fn, $time, a, bus.State, e.c, e.st, e.cs);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add_rec(input ctl_t c);
    exp_t e;
    e.c  = c;
    e.cs = 1'b0;
    e.st = '0;
    seq_q.push_back(e);
  endtask

  task automatic model(input logic [5:0] op, input logic [5:0] fn,
                       input logic zero, input logic ovf);
    ctl_t c;
    bit   trapped;
    seq_q.delete();
    for (int i = 0; i < MEM_WAIT - 1; i++) add_rec('0);
    c = '0; c.irw = 1; c.srcb = 2'b01; c.alu = 3'b001; c.pcw = 1; add_rec(c);
    c = '0; c.srcb = 2'b11; c.alu = 3'b001; c.aluow = 1; add_rec(c);
    trapped = 1'b0;
    case (op)
      6'h00: begin
        if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) begin
          c = '0; c.srca = 1; c.aluow = 1;
          c.alu = (fn == 6'h20) ? 3'b001 : (fn == 6'h22) ? 3'b010 : 3'b011;
          add_rec(c);
          trapped = TRAP && ovf && (fn != 6'h24);
          c = '0; c.regd = 1; c.regw = !trapped; add_rec(c);
        end else if (fn == 6'h00 || fn == 6'h02 || fn == 6'h03) begin
          c = '0; c.sh = 3'b001; add_rec(c);
          c = '0; c.sh = (fn == 6'h00) ? 3'b010 : (fn == 6'h02) ? 3'b011 : 3'b100;
          add_rec(c);
          c = '0; c.regd = 1; c.wsrc = 1; c.regw = 1; add_rec(c);
        end else if (fn == 6'h08) begin
          c = '0; c.pcs = 2'b11; c.pcw = 1; add_rec(c);
        end
      end
      6'h08: begin
        c = '0; c.srca = 1; c.srcb = 2'b10; c.alu = 3'b001; c.aluow = 1; add_rec(c);
        trapped = TRAP && ovf;
        c = '0; c.regw = !trapped; add_rec(c);
      end
      6'h23, 6'h2B: begin
        c = '0; c.srca = 1; c.srcb = 2'b10; c.alu = 3'b001; c.aluow = 1; add_rec(c);
        if (op == 6'h23) begin
          for (int i = 0; i < MEM_WAIT; i++) begin
            c = '0; c.iord = 1; add_rec(c);
          end
          c = '0; c.m2r = 1; c.regw = 1; add_rec(c);
        end else begin
          c = '0; c.iord = 1; c.memw = 1; add_rec(c);
        end
      end
      6'h04, 6'h05: begin
        c = '0; c.srca = 1; c.alu = 3'b010; c.pcs = 2'b01;
        c.pcw = (op == 6'h04) ? zero : !zero;
        add_rec(c);
      end
      6'h02: begin
        c = '0; c.pcs = 2'b10; c.pcw = 1; add_rec(c);
      end
      default: ;
    endcase
    if (trapped) begin
      c = '0; c.exc = 1; c.pcs = 2'b10; c.pcw = 1; add_rec(c);
    end
  endtask

  task automatic do_reset(input int ncyc);
    exp_t e;
    e    = '0;
    e.cs = 1'b1;
    e.st = S_RESET;
    reset = 1'b1;
    for (int i = 0; i < ncyc; i++) exp_q.push_back(e);
    repeat (ncyc) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < RSC; i++) exp_q.push_back(e);
    repeat (RSC) @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic zero, input logic ovf, input int cut);
    int n;
    bit abort;
    model(op, fn, zero, ovf);
    cur_op = op;
    cur_fn = fn;
    bus.OPCODE   = op;
    bus.Funct    = fn;
    bus.Zero     = zero;
    bus.Overflow = ovf;
    abort = (cut > 0) && (cut < seq_q.size());
    n = abort ? cut : seq_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back(seq_q[i]);
    repeat (n) @(posedge clk);
    #1;
    if (abort) do_reset(3);
  endtask

  initial begin
    logic [5:0] op, fn;
    logic       z, v;
    int         cut;
    bus.OPCODE   = '0;
    bus.Funct    = '0;
    bus.Zero     = 1'b0;
    bus.Overflow = 1'b0;
    cur_op = '0;
    cur_fn = '0;
    @(posedge clk);
    #1;
    do_reset(3);

    run_instr(6'h00, 6'h20, 0, 0, 0);
    run_instr(6'h00, 6'h20, 0, 0, MEM_WAIT + 1);
    run_instr(6'h23, 6'h11, 0, 0, 0);
    run_instr(6'h2B, 6'h11, 0, 0, 0);
    run_instr(6'h04, 6'h00, 1, 0, 0);
    run_instr(6'h04, 6'h00, 0, 0, 0);
    run_instr(6'h05, 6'h00, 1, 0, 0);
    run_instr(6'h05, 6'h00, 0, 0, 0);
    run_instr(6'h00, 6'h03, 0, 0, 0);
    run_instr(6'h08, 6'h00, 0, 1, 0);
    run_instr(6'h00, 6'h22, 0, 1, 0);
    run_instr(6'h00, 6'h24, 0, 1, 0);
    run_instr(6'h02, 6'h00, 0, 0, 0);
    run_instr(6'h00, 6'h08, 0, 0, 0);
    run_instr(6'h00, 6'h2A, 0, 0, 0);
    run_instr(6'h3F, 6'h00, 0, 0, 0);

    for (int k = 0; k < 300; k++) begin
      fn = 6'($urandom_range(0, 63));
      case ($urandom_range(0, 14))
        0:  begin op = 6'h00; fn = 6'h20; end
        1:  begin op = 6'h00; fn = 6'h22; end
        2:  begin op = 6'h00; fn = 6'h24; end
        3:  begin op = 6'h00; fn = 6'h00; end
        4:  begin op = 6'h00; fn = 6'h02; end
        5:  begin op = 6'h00; fn = 6'h03; end
        6:  begin op = 6'h00; fn = 6'h08; end
        7:  begin op = 6'h00; fn = 6'h2A; end
        8:  op = 6'h08;
        9:  op = 6'h23;
        10: op = 6'h2B;
        11: op = 6'h04;
        12: op = 6'h05;
        13: op = 6'h02;
        default: op = 6'h3F;
      endcase
      z   = 1'($urandom_range(0, 1));
      v   = 1'($urandom_range(0, 1));
      cut = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 5)) : 0;
      run_instr(op, fn, z, v, cut);
    end

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard: %0d expected records never checked", exp_q.size());
    end
    if (tests < 300) begin
      fails++;
      $display("FAIL scoreboard: only %0d cycle checks performed", tests);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    if (fails == 0) $display("PASS");
    else            $display("FAIL");
    $finish;
  end

endmodule
